// File: rtl/unstriper.sv
// ============================================================================
// unstriper
// ----------------------------------------------------------------------------
// Recombines two byte lanes into one byte stream. Each lane has its own small
// FIFO. A two-state machine names the lane whose byte must come out next
// (WAIT_0 / WAIT_1). When that lane has a byte it is popped into the
// registered output and the expectation flips to the other lane. When it has
// no byte the output stalls, even if the other lane has bytes waiting, so
// lane order L0, L1, L0, L1 ... is always kept.
//
// A byte written at one edge can be popped no earlier than the next edge:
// there is no write-to-read bypass. A write to a full FIFO is dropped unless
// that FIFO is popped at the same edge.
//
// Configuration macro:
//   UNSTRIPER_OVERFLOW_FLAG_EN  defined   -> overflow is a sticky flag that is
//                                            set by any dropped write and is
//                                            cleared only by reset.
//                               undefined -> overflow is tied to 0 and no flag
//                                            register exists. Drop-on-full
//                                            behaviour is unchanged.
//
// Parameters:
//   FIFO_DEPTH        entries per lane FIFO (power of two, 2..16)
//
// Ports:
//   clk_2f            in   sole clock, rising edge
//   reset_L           in   synchronous, active-low reset
//   data_stripe_0     in   [7:0] lane 0 byte
//   valid_stripe_0    in   lane 0 byte valid this cycle
//   data_stripe_1     in   [7:0] lane 1 byte
//   valid_stripe_1    in   lane 1 byte valid this cycle
//   data_unstripped   out  [7:0] recombined byte (registered, held when idle)
//   valid_unstripped  out  data_unstripped valid (registered)
//   overflow          out  sticky lane FIFO overflow flag
// ============================================================================
module unstriper #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_2f,
   input  logic       reset_L,
   input  logic [7:0] data_stripe_0,
   input  logic       valid_stripe_0,
   input  logic [7:0] data_stripe_1,
   input  logic       valid_stripe_1,
   output logic [7:0] data_unstripped,
   output logic       valid_unstripped,
   output logic       overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef enum logic {
      WAIT_0 = 1'b0,
      WAIT_1 = 1'b1
   } state_e;

   // ------------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------------
   logic [7:0]       mem0_q [FIFO_DEPTH];
   logic [7:0]       mem1_q [FIFO_DEPTH];

   logic [PTR_W-1:0] wr0_q, wr0_d, rd0_q, rd0_d;
   logic [PTR_W-1:0] wr1_q, wr1_d, rd1_q, rd1_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   state_e           state_q;
   logic [7:0]       data_q;
   logic             valid_q;

   // ------------------------------------------------------------------------
   // Per-edge control
   // ------------------------------------------------------------------------
   logic       pop0_s, pop1_s;
   logic       full0_s, full1_s;
   logic       push0_s, push1_s;
   logic [7:0] head0_s, head1_s;

   // Pop/push decisions and the head bytes offered to the output register.
   always_comb begin
      pop0_s  = 1'b0;
      pop1_s  = 1'b0;
      full0_s = 1'b0;
      full1_s = 1'b0;
      push0_s = 1'b0;
      push1_s = 1'b0;
      head0_s = mem0_q[rd0_q];
      head1_s = mem1_q[rd1_q];

      // Only the expected lane may pop. An empty count blocks the pop even
      // when a write arrives at the same edge, so there is no bypass.
      pop0_s  = (state_q == WAIT_0) && (cnt0_q != '0);
      pop1_s  = (state_q == WAIT_1) && (cnt1_q != '0);

      full0_s = (cnt0_q == DEPTH_C);
      full1_s = (cnt1_q == DEPTH_C);

      // A full FIFO still takes a write when its head leaves at the same edge.
      push0_s = valid_stripe_0 && (!full0_s || pop0_s);
      push1_s = valid_stripe_1 && (!full1_s || pop1_s);
   end

   // Next pointers and counts for both lane FIFOs.
   always_comb begin
      wr0_d  = wr0_q;
      rd0_d  = rd0_q;
      wr1_d  = wr1_q;
      rd1_d  = rd1_q;
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;

      if (push0_s) begin
         wr0_d = wr0_q + PTR_ONE;
      end else begin
         wr0_d = wr0_q;
      end

      if (pop0_s) begin
         rd0_d = rd0_q + PTR_ONE;
      end else begin
         rd0_d = rd0_q;
      end

      if (push1_s) begin
         wr1_d = wr1_q + PTR_ONE;
      end else begin
         wr1_d = wr1_q;
      end

      if (pop1_s) begin
         rd1_d = rd1_q + PTR_ONE;
      end else begin
         rd1_d = rd1_q;
      end

      // A push and a pop at the same edge leave the count unchanged.
      case ({push0_s, pop0_s})
         2'b10:   cnt0_d = cnt0_q + CNT_ONE;
         2'b01:   cnt0_d = cnt0_q - CNT_ONE;
         default: cnt0_d = cnt0_q;
      endcase

      case ({push1_s, pop1_s})
         2'b10:   cnt1_d = cnt1_q + CNT_ONE;
         2'b01:   cnt1_d = cnt1_q - CNT_ONE;
         default: cnt1_d = cnt1_q;
      endcase
   end

   // FIFO pointer and count registers. Reset discards all buffered bytes.
   always_ff @(posedge clk_2f) begin
      if (!reset_L) begin
         wr0_q  <= '0;
         rd0_q  <= '0;
         cnt0_q <= '0;
         wr1_q  <= '0;
         rd1_q  <= '0;
         cnt1_q <= '0;
      end else begin
         wr0_q  <= wr0_d;
         rd0_q  <= rd0_d;
         cnt0_q <= cnt0_d;
         wr1_q  <= wr1_d;
         rd1_q  <= rd1_d;
         cnt1_q <= cnt1_d;
      end
   end

   // Lane FIFO storage. Bytes presented during reset are ignored.
   // On a full FIFO that pops and pushes at the same edge, the write and read
   // slots coincide. The output register captures the old head, and the new
   // byte becomes the tail.
   always_ff @(posedge clk_2f) begin
      if (reset_L && push0_s) begin
         mem0_q[wr0_q] <= data_stripe_0;
      end
      if (reset_L && push1_s) begin
         mem1_q[wr1_q] <= data_stripe_1;
      end
   end

   // Lane-order state machine with registered output byte and valid.
   always_ff @(posedge clk_2f) begin
      if (!reset_L) begin
         state_q <= WAIT_0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            WAIT_0: begin
               if (pop0_s) begin
                  data_q  <= head0_s;
                  valid_q <= 1'b1;
                  state_q <= WAIT_1;
               end else begin
                  // Stall: the byte is held and lane 1 bytes stay queued.
                  valid_q <= 1'b0;
               end
            end
            WAIT_1: begin
               if (pop1_s) begin
                  data_q  <= head1_s;
                  valid_q <= 1'b1;
                  state_q <= WAIT_0;
               end else begin
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= WAIT_0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_unstripped  = data_q;
   assign valid_unstripped = valid_q;

`ifdef UNSTRIPER_OVERFLOW_FLAG_EN
   logic overflow_q;
   logic drop_s;

   // A write is lost only when its FIFO is full and is not popped at that edge.
   assign drop_s = (valid_stripe_0 && full0_s && !pop0_s) ||
                   (valid_stripe_1 && full1_s && !pop1_s);

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clk_2f) begin
      if (!reset_L) begin
         overflow_q <= 1'b0;
      end else if (drop_s) begin
         overflow_q <= 1'b1;
      end else begin
         overflow_q <= overflow_q;
      end
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_unstriper.sv
// ============================================================================
// tb_unstriper
// ----------------------------------------------------------------------------
// Self-checking bench for unstriper (FIFO_DEPTH = 4).
// The directed vector table covers reset, single bytes and lane-order stalls.
// Hand-written sequences cover alternating streaming, drop-on-full, write on a
// full FIFO with a pop, and reset while bytes are buffered. A randomized phase
// is checked against a queue-based reference model.
// ============================================================================
module tb_unstriper;

   localparam int DEPTH = 4;
`ifdef UNSTRIPER_OVERFLOW_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic       clk_2f = 1'b0;
   logic       reset_L;
   logic [7:0] data_stripe_0, data_stripe_1;
   logic       valid_stripe_0, valid_stripe_1;
   logic [7:0] data_unstripped;
   logic       valid_unstripped;
   logic       overflow;

   always #5 clk_2f = ~clk_2f;

   unstriper #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_2f          (clk_2f),
      .reset_L         (reset_L),
      .data_stripe_0   (data_stripe_0),
      .valid_stripe_0  (valid_stripe_0),
      .data_stripe_1   (data_stripe_1),
      .valid_stripe_1  (valid_stripe_1),
      .data_unstripped (data_unstripped),
      .valid_unstripped(valid_unstripped),
      .overflow        (overflow)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: one queue per lane plus the expected-lane index.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         m_lane  = 0;
   logic       m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;
   logic       m_ovf   = 1'b0;

   // Output capture for sequence checks.
   logic [7:0] out_q[$];
   logic [7:0] exp_q[$];
   int         cyc, first_v, last_v, n_v;

   typedef struct packed {
      logic       rst_n;
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       ev;
      logic [7:0] ed;
   } vec_t;

   localparam int NV = 17;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1,
                               input logic ev, input logic [7:0] ed);
      vec_t v;
      v.rst_n = r; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ev = ev; v.ed = ed;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of the behaviour: pop the expected lane, then accept writes.
   function automatic void model_edge(input logic rst_n, input logic v0, input logic [7:0] d0,
                                      input logic v1, input logic [7:0] d1);
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         m_lane  = 0;
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_ovf   = 1'b0;
      end else begin
         if (m_lane == 0 && q0.size() > 0) begin
            m_data = q0.pop_front(); m_valid = 1'b1; m_lane = 1;
         end else if (m_lane == 1 && q1.size() > 0) begin
            m_data = q1.pop_front(); m_valid = 1'b1; m_lane = 0;
         end else begin
            m_valid = 1'b0;
         end
         // Any pop has already happened, so a write finds room iff not dropped.
         if (v0) begin
            if (q0.size() < DEPTH) q0.push_back(d0);
            else if (OVF_EN) m_ovf = 1'b1;
         end
         if (v1) begin
            if (q1.size() < DEPTH) q1.push_back(d1);
            else if (OVF_EN) m_ovf = 1'b1;
         end
      end
   endfunction

   task automatic step(input logic rst_n, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input string tag);
      reset_L        = rst_n;
      valid_stripe_0 = v0;
      data_stripe_0  = d0;
      valid_stripe_1 = v1;
      data_stripe_1  = d1;
      @(posedge clk_2f);
      model_edge(rst_n, v0, d0, v1, d1);
      #1;
      cmp({tag, "/valid"}, 32'(valid_unstripped), 32'(m_valid));
      cmp({tag, "/data"},  32'(data_unstripped),  32'(m_data));
      cmp({tag, "/ovf"},   32'(overflow),         32'(m_ovf));
      if (valid_unstripped === 1'b1) begin
         out_q.push_back(data_unstripped);
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
         n_v++;
      end
      cyc++;
   endtask

   task automatic clear_capture();
      out_q.delete();
      cyc = 0; first_v = -1; last_v = -1; n_v = 0;
   endtask

   task automatic check_out(input string name);
      cmp({name, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         cmp($sformatf("%s[%0d]", name, i), 32'(out_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_L = 1'b0;
      valid_stripe_0 = 1'b0; data_stripe_0 = 8'h00;
      valid_stripe_1 = 1'b0; data_stripe_1 = 8'h00;
      clear_capture();

      // Expected values are those seen just after each edge.
      tbl[0]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00); // reset
      tbl[1]  = mk(1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00); // lane0 0x11 sampled
      tbl[2]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h11);
      tbl[3]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 8'h11); // lane1 0x22 sampled
      tbl[4]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h22);
      tbl[5]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h22);
      tbl[6]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'hA1, 1'b0, 8'h22); // lane1 first
      tbl[7]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'hA2, 1'b0, 8'h22);
      tbl[8]  = mk(1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h22);
      tbl[9]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01);
      tbl[10] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA1);
      tbl[11] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA1); // A2 must wait
      tbl[12] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA1);
      tbl[13] = mk(1'b1, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 8'hA1);
      tbl[14] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02);
      tbl[15] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA2);
      tbl[16] = mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA2);

      for (int i = 0; i < NV; i++) begin
         reset_L        = tbl[i].rst_n;
         valid_stripe_0 = tbl[i].v0;
         data_stripe_0  = tbl[i].d0;
         valid_stripe_1 = tbl[i].v1;
         data_stripe_1  = tbl[i].d1;
         @(posedge clk_2f);
         model_edge(tbl[i].rst_n, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
         #1;
         cmp($sformatf("vec%0d/valid", i), 32'(valid_unstripped), 32'(tbl[i].ev));
         cmp($sformatf("vec%0d/data", i),  32'(data_unstripped),  32'(tbl[i].ed));
         cmp($sformatf("vec%0d/ovf", i),   32'(overflow),         32'(0));
      end

      // Alternating lanes, 16 bytes each: a contiguous interleaved stream.
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "alt_rst");
      clear_capture();
      for (int k = 0; k < 16; k++) begin
         step(1'b1, 1'b1, 8'(k), 1'b0, 8'h00, "alt");
         step(1'b1, 1'b0, 8'h00, 1'b1, 8'(8'h80 + k), "alt");
      end
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "alt");
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "alt");
      exp_q.delete();
      for (int i = 0; i < 32; i++)
         exp_q.push_back((i % 2 == 0) ? 8'(i / 2) : 8'(8'h80 + i / 2));
      check_out("alt_seq");
      cmp("alt_contig", 32'(last_v - first_v + 1), 32'(n_v));
      cmp("alt_first", 32'(first_v), 32'(1));
      cmp("alt_ovf", 32'(overflow), 32'(0));

      // Lane1 overfills while lane0 is idle; the 5th byte is lost.
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "ovf_rst");
      clear_capture();
      for (int k = 0; k < 5; k++)
         step(1'b1, 1'b0, 8'h00, 1'b1, 8'(8'hB0 + k), "ovf_fill");
      cmp("ovf_flag", 32'(overflow), 32'(OVF_EN));
      for (int k = 0; k < 5; k++)
         step(1'b1, 1'b1, 8'(8'h30 + k), 1'b0, 8'h00, "ovf_drain");
      for (int k = 0; k < 6; k++)
         step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "ovf_drain");
      exp_q = '{8'h30, 8'hB0, 8'h31, 8'hB1, 8'h32, 8'hB2, 8'h33, 8'hB3, 8'h34};
      check_out("ovf_seq");
      cmp("ovf_sticky", 32'(overflow), 32'(OVF_EN));

      // Write to a full lane0 FIFO on the edge it pops: the write is kept.
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "full_rst");
      clear_capture();
      step(1'b1, 1'b1, 8'hC0, 1'b0, 8'h00, "full");
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "full");
      for (int k = 1; k <= 4; k++)
         step(1'b1, 1'b1, 8'(8'hC0 + k), 1'b0, 8'h00, "full");
      step(1'b1, 1'b0, 8'h00, 1'b1, 8'hD0, "full");
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "full");
      step(1'b1, 1'b1, 8'hC5, 1'b0, 8'h00, "full");
      cmp("full_pop_ovf", 32'(overflow), 32'(0));
      for (int k = 0; k < 4; k++)
         step(1'b1, 1'b0, 8'h00, 1'b1, 8'(8'hE0 + k), "full");
      for (int k = 0; k < 8; k++)
         step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "full");
      exp_q = '{8'hC0, 8'hD0, 8'hC1, 8'hE0, 8'hC2, 8'hE1, 8'hC3, 8'hE2, 8'hC4, 8'hE3, 8'hC5};
      check_out("full_seq");

      // Reset with three lane0 bytes buffered and a nonzero held output.
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "mid_rst0");
      step(1'b1, 1'b1, 8'h44, 1'b0, 8'h00, "mid");
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "mid");
      for (int k = 0; k < 3; k++)
         step(1'b1, 1'b1, 8'(8'h45 + k), 1'b0, 8'h00, "mid");
      step(1'b0, 1'b1, 8'h77, 1'b1, 8'h78, "mid_rst");
      cmp("mid_rst_valid", 32'(valid_unstripped), 32'(0));
      cmp("mid_rst_data",  32'(data_unstripped),  32'(8'h00));
      cmp("mid_rst_ovf",   32'(overflow),         32'(0));
      clear_capture();
      step(1'b1, 1'b0, 8'h00, 1'b1, 8'h55, "post");
      step(1'b1, 1'b1, 8'h66, 1'b0, 8'h00, "post");
      for (int k = 0; k < 4; k++)
         step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "post");
      exp_q = '{8'h66, 8'h55};
      check_out("post_seq");

      // Randomized traffic with rare resets, checked cycle by cycle.
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "rnd_rst");
      for (int blk = 0; blk < 6; blk++) begin
         int p0, p1;
         p0 = int'($urandom_range(10, 95));
         p1 = int'($urandom_range(10, 95));
         for (int c = 0; c < 100; c++) begin
            logic r, v0, v1;
            r  = ($urandom_range(0, 99) != 0);
            v0 = (int'($urandom_range(0, 99)) < p0);
            v1 = (int'($urandom_range(0, 99)) < p1);
            step(r, v0, 8'($urandom), v1, 8'($urandom), "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
